// File: rtl/t5_lsu_if.sv
// t5_lsu_if: data-side Wishbone port of the t5 load/store unit.
//   master modport (LSU): drives dwb_adr, dwb_dto, dwb_sel, dwb_stb, dwb_wre;
//                         receives dwb_ack, dwb_dti.
//   slave modport (memory): the mirror image.
interface t5_lsu_if #(
  parameter int XLEN = 32
);
  logic [XLEN-3:0] dwb_adr;   // word address (byte address [XLEN-1:2])
  logic [XLEN-1:0] dwb_dto;   // write data, lane-replicated
  logic [3:0]      dwb_sel;   // byte-lane select
  logic            dwb_stb;   // strobe, held until ack
  logic            dwb_wre;   // 1 = write cycle
  logic            dwb_ack;   // slave acknowledge
  logic [XLEN-1:0] dwb_dti;   // read data, valid with dwb_ack

  modport master (
    output dwb_adr, dwb_dto, dwb_sel, dwb_stb, dwb_wre,
    input  dwb_ack, dwb_dti
  );

  modport slave (
    input  dwb_adr, dwb_dto, dwb_sel, dwb_stb, dwb_wre,
    output dwb_ack, dwb_dti
  );
endinterface

// File: rtl/t5_lsu.sv
// t5_lsu: load/store unit between the t5 execute stage and the data bus.
// Takes one request at a time, runs a single-beat bus cycle, returns
// extracted/extended load data with a one-cycle lsu_rdy pulse.
// Ports:
//   sys_clk, sys_rst (async, active-high), sys_ena (global enable)
//   lsu_req/lsu_wre/lsu_siz/lsu_sgn/lsu_adr/lsu_dat : request from core
//   lsu_stall : combinational hold to the core
//   lsu_rdy/lsu_res/lsu_err : registered completion / result / error pulse
//   dwb : data bus master port (t5_lsu_if.master)
module t5_lsu #(
  parameter int XLEN = 32
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            sys_ena,
  input  logic            lsu_req,
  input  logic            lsu_wre,
  input  logic [1:0]      lsu_siz,
  input  logic            lsu_sgn,
  input  logic [XLEN-1:0] lsu_adr,
  input  logic [XLEN-1:0] lsu_dat,
  output logic            lsu_stall,
  output logic            lsu_rdy,
  output logic [XLEN-1:0] lsu_res,
  output logic            lsu_err,
  t5_lsu_if.master        dwb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [XLEN-3:0] dwb_adr_q;
  logic [XLEN-1:0] dwb_dto_q;
  logic [3:0]      dwb_sel_q;
  logic            dwb_stb_q;
  logic            dwb_wre_q;
  logic            lsu_rdy_q;
  logic            lsu_err_q;
  logic [XLEN-1:0] lsu_res_q;
  // Request attributes kept for the load-extraction step.
  logic [1:0]      off_q;
  logic [1:0]      siz_q;
  logic            sgn_q;

  logic            ok_s;
  logic [XLEN-1:0] res_d;

  // Size legal and address naturally aligned for that size.
  function automatic logic legal_f(input logic [1:0] siz, input logic [1:0] off);
    case (siz)
      2'b00:   legal_f = 1'b1;
      2'b01:   legal_f = ~off[0];
      2'b10:   legal_f = (off == 2'b00);
      default: legal_f = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] sel_f(input logic [1:0] siz, input logic [1:0] off);
    case (siz)
      2'b00:   sel_f = 4'b0001 << off;
      2'b01:   sel_f = off[1] ? 4'hC : 4'h3;
      2'b10:   sel_f = 4'hF;
      default: sel_f = 4'h0;
    endcase
  endfunction

  // Store data is replicated into every lane so the slave picks by dwb_sel.
  function automatic logic [XLEN-1:0] dto_f(input logic [1:0] siz, input logic [XLEN-1:0] dat);
    case (siz)
      2'b00:   dto_f = {4{dat[7:0]}};
      2'b01:   dto_f = {2{dat[15:0]}};
      default: dto_f = dat;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extract_f(input logic [XLEN-1:0] dti, input logic [1:0] off,
                                                input logic [1:0] siz, input logic sgn);
    logic [XLEN-1:0] sh;
    sh = dti >> {off, 3'b000};
    case (siz)
      2'b00:   extract_f = {{(XLEN-8){sgn & sh[7]}}, sh[7:0]};
      2'b01:   extract_f = {{(XLEN-16){sgn & sh[15]}}, sh[15:0]};
      default: extract_f = sh;
    endcase
  endfunction

  assign ok_s  = legal_f(lsu_siz, lsu_adr[1:0]);
  assign res_d = dwb_wre_q ? {XLEN{1'b0}} : extract_f(dwb.dwb_dti, off_q, siz_q, sgn_q);

  // Stall covers the accept cycle as well, so the core holds until DONE.
  assign lsu_stall = (state_q == BUSY) |
                     ((state_q == IDLE) & sys_ena & lsu_req & ok_s);

  assign lsu_rdy      = lsu_rdy_q;
  assign lsu_err      = lsu_err_q;
  assign lsu_res      = lsu_res_q;
  assign dwb.dwb_adr  = dwb_adr_q;
  assign dwb.dwb_dto  = dwb_dto_q;
  assign dwb.dwb_sel  = dwb_sel_q;
  assign dwb.dwb_stb  = dwb_stb_q;
  assign dwb.dwb_wre  = dwb_wre_q;

  // Request FSM with all outputs registered; rdy/err default low so they pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      dwb_adr_q <= {(XLEN-2){1'b0}};
      dwb_dto_q <= {XLEN{1'b0}};
      dwb_sel_q <= 4'h0;
      dwb_stb_q <= 1'b0;
      dwb_wre_q <= 1'b0;
      lsu_rdy_q <= 1'b0;
      lsu_err_q <= 1'b0;
      lsu_res_q <= {XLEN{1'b0}};
      off_q     <= 2'b00;
      siz_q     <= 2'b00;
      sgn_q     <= 1'b0;
    end else begin
      lsu_rdy_q <= 1'b0;
      lsu_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sys_ena && lsu_req) begin
            if (ok_s) begin
              dwb_adr_q <= lsu_adr[XLEN-1:2];
              dwb_sel_q <= sel_f(lsu_siz, lsu_adr[1:0]);
              dwb_dto_q <= dto_f(lsu_siz, lsu_dat);
              dwb_wre_q <= lsu_wre;
              dwb_stb_q <= 1'b1;
              off_q     <= lsu_adr[1:0];
              siz_q     <= lsu_siz;
              sgn_q     <= lsu_sgn;
              state_q   <= BUSY;
            end else begin
              lsu_err_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          // Ack is taken even with sys_ena low so the bus cycle always closes.
          if (dwb.dwb_ack) begin
            dwb_stb_q <= 1'b0;
            lsu_res_q <= res_d;
            lsu_rdy_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (sys_ena) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t5_lsu.sv
// tb_t5_lsu: directed self-checking bench for t5_lsu with a delayed-ack memory slave.
module tb_t5_lsu;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        sys_ena;
  logic        lsu_req;
  logic        lsu_wre;
  logic [1:0]  lsu_siz;
  logic        lsu_sgn;
  logic [31:0] lsu_adr;
  logic [31:0] lsu_dat;
  logic        lsu_stall;
  logic        lsu_rdy;
  logic [31:0] lsu_res;
  logic        lsu_err;

  t5_lsu_if #(.XLEN(32)) dwb ();

  t5_lsu #(.XLEN(32)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .sys_ena  (sys_ena),
    .lsu_req  (lsu_req),
    .lsu_wre  (lsu_wre),
    .lsu_siz  (lsu_siz),
    .lsu_sgn  (lsu_sgn),
    .lsu_adr  (lsu_adr),
    .lsu_dat  (lsu_dat),
    .lsu_stall(lsu_stall),
    .lsu_rdy  (lsu_rdy),
    .lsu_res  (lsu_res),
    .lsu_err  (lsu_err),
    .dwb      (dwb)
  );

  always #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Slave controls, written only by the stimulus block.
  int        ack_delay = 0;
  bit        ovr_en    = 1'b0;
  bit [31:0] ovr_dti   = 32'h0;
  bit [31:0] ref_mem [16];

  // Slave state.
  bit [31:0] mem [16];
  int        wcnt = 0;

  // Memory slave: raises ack after ack_delay wait cycles, applies writes at ack.
  always @(negedge sys_clk) begin
    if (dwb.dwb_stb && !dwb.dwb_ack) begin
      if (wcnt >= ack_delay) begin
        dwb.dwb_ack = 1'b1;
        dwb.dwb_dti = ovr_en ? ovr_dti : mem[dwb.dwb_adr[3:0]];
        if (dwb.dwb_wre) begin
          for (int k = 0; k < 4; k++)
            if (dwb.dwb_sel[k]) mem[dwb.dwb_adr[3:0]][8*k +: 8] = dwb.dwb_dto[8*k +: 8];
        end
      end else begin
        wcnt++;
      end
    end else begin
      dwb.dwb_ack = 1'b0;
      dwb.dwb_dti = 32'h0;
      wcnt = 0;
    end
  end

  // Bus monitor: counts rdy pulses, strobe rises and the minimum strobe-low gap.
  int rdy_cnt = 0;
  int stb_rises = 0;
  int low_run = 0;
  int min_gap = 1000;
  bit prev_stb = 1'b0;
  bit seen_stb = 1'b0;
  always @(negedge sys_clk) begin
    if (lsu_rdy === 1'b1) rdy_cnt++;
    if (dwb.dwb_stb === 1'b1) begin
      if (!prev_stb) begin
        stb_rises++;
        if (seen_stb && low_run < min_gap) min_gap = low_run;
      end
      seen_stb = 1'b1;
      low_run = 0;
      prev_stb = 1'b1;
    end else begin
      low_run++;
      prev_stb = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit [3:0] exp_sel(input bit [1:0] s, input bit [1:0] off);
    if (s == 2'b00) return 4'b0001 << off;
    if (s == 2'b01) return (off == 2'b10) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit [31:0] exp_dto(input bit [1:0] s, input bit [31:0] d);
    if (s == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (s == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic bit [31:0] exp_load(input bit [31:0] w, input bit [1:0] s, input bit g,
                                         input bit [1:0] off);
    bit [7:0]  b;
    bit [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    if (s == 2'b00) return (g && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
    if (s == 2'b01) return (g && h[15]) ? {16'hFFFF, h} : {16'h0, h};
    return w;
  endfunction

  task automatic ref_store(input bit [31:0] a, input bit [1:0] s, input bit [31:0] d);
    bit [3:0]  sl;
    bit [31:0] dt;
    sl = exp_sel(s, a[1:0]);
    dt = exp_dto(s, d);
    for (int k = 0; k < 4; k++)
      if (sl[k]) ref_mem[a[5:2]][8*k +: 8] = dt[8*k +: 8];
  endtask

  // Issues one request and follows it to lsu_rdy or lsu_err (bounded).
  task automatic txn(input bit w, input bit [1:0] s, input bit g, input bit [31:0] a,
                     input bit [31:0] d, output bit [31:0] res, output bit err,
                     output int lat, output bit [3:0] sel, output bit [29:0] wadr,
                     output bit [31:0] dto, output bit wr, output bit stable,
                     output bit stall_done, output bit done);
    bit seen;
    lsu_wre = w; lsu_siz = s; lsu_sgn = g; lsu_adr = a; lsu_dat = d; lsu_req = 1'b1;
    res = 32'h0; err = 1'b0; lat = 0; sel = 4'h0; wadr = 30'h0; dto = 32'h0; wr = 1'b0;
    stable = 1'b1; stall_done = 1'b1; done = 1'b0; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge sys_clk); #1;
      lat++;
      if (lsu_err === 1'b1) begin err = 1'b1; done = 1'b1; break; end
      if (dwb.dwb_stb === 1'b1) begin
        if (!seen) begin
          sel = dwb.dwb_sel; wadr = dwb.dwb_adr; dto = dwb.dwb_dto; wr = dwb.dwb_wre;
          seen = 1'b1;
        end else if (dwb.dwb_sel !== sel || dwb.dwb_adr !== wadr ||
                     dwb.dwb_dto !== dto || dwb.dwb_wre !== wr || lsu_stall !== 1'b1) begin
          stable = 1'b0;
        end
      end
      if (lsu_rdy === 1'b1) begin
        res = lsu_res; stall_done = lsu_stall; done = 1'b1; break;
      end
    end
    lsu_req = 1'b0;
  endtask

  initial begin
    bit [31:0] res, dto;
    bit [29:0] wadr;
    bit [3:0]  sel;
    bit        err, wr, stable, stall_done, done;
    int        lat, r0, s0;
    bit        w, g;
    bit [1:0]  s, off;
    bit [3:0]  idx;
    bit [31:0] a, d;

    sys_rst = 1'b1; sys_ena = 1'b1; lsu_req = 1'b0; lsu_wre = 1'b0;
    lsu_siz = 2'b00; lsu_sgn = 1'b0; lsu_adr = 32'h0; lsu_dat = 32'h0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_stb",   {31'h0, dwb.dwb_stb}, 32'h0);
    chk("rst_sel",   {28'h0, dwb.dwb_sel}, 32'h0);
    chk("rst_adr",   {2'b00, dwb.dwb_adr}, 32'h0);
    chk("rst_dto",   dwb.dwb_dto, 32'h0);
    chk("rst_wre",   {31'h0, dwb.dwb_wre}, 32'h0);
    chk("rst_rdy",   {31'h0, lsu_rdy}, 32'h0);
    chk("rst_err",   {31'h0, lsu_err}, 32'h0);
    chk("rst_res",   lsu_res, 32'h0);
    chk("rst_stall", {31'h0, lsu_stall}, 32'h0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // Store byte with 3 wait cycles.
    ack_delay = 3;
    txn(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, res, err, lat, sel, wadr, dto, wr,
        stable, stall_done, done);
    ref_store(32'h0000_1003, 2'b00, 32'h0000_00A5);
    chk("sb_done",   {31'h0, done}, 32'h1);
    chk("sb_adr",    {2'b00, wadr}, 32'h0000_0400);
    chk("sb_sel",    {28'h0, sel}, 32'h8);
    chk("sb_dto",    dto, 32'hA5A5_A5A5);
    chk("sb_wre",    {31'h0, wr}, 32'h1);
    chk("sb_stable", {31'h0, stable}, 32'h1);
    chk("sb_lat",    lat, 32'd5);
    chk("sb_res",    res, 32'h0);
    chk("sb_stall_done", {31'h0, stall_done}, 32'h0);
    @(posedge sys_clk); #1;
    chk("sb_rdy_pulse", {31'h0, lsu_rdy}, 32'h0);

    // Directed loads with forced read data.
    ack_delay = 0; ovr_en = 1'b1;
    ovr_dti = 32'h8001_1234;
    txn(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, res, err, lat, sel, wadr, dto, wr,
        stable, stall_done, done);
    chk("lhs_sel", {28'h0, sel}, 32'hC);
    chk("lhs_adr", {2'b00, wadr}, 32'h0000_0800);
    chk("lhs_wre", {31'h0, wr}, 32'h0);
    chk("lhs_res", res, 32'hFFFF_8001);
    txn(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, res, err, lat, sel, wadr, dto, wr,
        stable, stall_done, done);
    chk("lhu_res", res, 32'h0000_8001);
    ovr_dti = 32'h1234_80FF;
    txn(1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0, res, err, lat, sel, wadr, dto, wr,
        stable, stall_done, done);
    chk("lbs_sel", {28'h0, sel}, 32'h2);
    chk("lbs_res", res, 32'hFFFF_FF80);
    ovr_dti = 32'hDEAD_BEEF;
    ack_delay = 2;
    txn(1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0, res, err, lat, sel, wadr, dto, wr,
        stable, stall_done, done);
    chk("lw_sel", {28'h0, sel}, 32'hF);
    chk("lw_res", res, 32'hDEAD_BEEF);
    chk("lw_stable", {31'h0, stable}, 32'h1);
    @(posedge sys_clk); #1;

    // Misaligned word, then illegal size.
    s0 = stb_rises;
    lsu_wre = 1'b0; lsu_siz = 2'b10; lsu_sgn = 1'b0; lsu_adr = 32'h0000_3002; lsu_req = 1'b1;
    #1;
    chk("mis_stall", {31'h0, lsu_stall}, 32'h0);
    @(posedge sys_clk); #1;
    chk("mis_err", {31'h0, lsu_err}, 32'h1);
    lsu_req = 1'b0;
    @(posedge sys_clk); #1;
    chk("mis_err_pulse", {31'h0, lsu_err}, 32'h0);
    lsu_siz = 2'b11; lsu_adr = 32'h0000_3000; lsu_req = 1'b1;
    #1;
    chk("ill_stall", {31'h0, lsu_stall}, 32'h0);
    @(posedge sys_clk); #1;
    chk("ill_err", {31'h0, lsu_err}, 32'h1);
    lsu_req = 1'b0;
    @(posedge sys_clk); #1;
    chk("ill_err_pulse", {31'h0, lsu_err}, 32'h0);
    repeat (2) @(posedge sys_clk);
    #1;
    chk("err_no_stb", stb_rises - s0, 32'd0);

    // sys_ena low holds off acceptance; result from the last load is retained.
    sys_ena = 1'b0;
    lsu_wre = 1'b0; lsu_siz = 2'b10; lsu_sgn = 1'b0; lsu_adr = 32'h0000_2000; lsu_req = 1'b1;
    s0 = stb_rises;
    #1;
    chk("ena_stall", {31'h0, lsu_stall}, 32'h0);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("ena_no_stb", stb_rises - s0 + {31'h0, dwb.dwb_stb}, 32'd0);
    chk("ena_stall_hold", {31'h0, lsu_stall}, 32'h0);
    chk("res_held", lsu_res, 32'hDEAD_BEEF);
    sys_ena = 1'b1;
    ovr_dti = 32'h0BAD_F00D; ack_delay = 1;
    txn(1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0, res, err, lat, sel, wadr, dto, wr,
        stable, stall_done, done);
    chk("ena_resume_res", res, 32'h0BAD_F00D);
    chk("ena_resume_lat", lat, 32'd3);

    // Reset asserted while BUSY.
    ack_delay = 20;
    @(posedge sys_clk); #1;
    lsu_wre = 1'b0; lsu_siz = 2'b10; lsu_adr = 32'h0000_0000; lsu_req = 1'b1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    chk("rb_stb_busy", {31'h0, dwb.dwb_stb}, 32'h1);
    r0 = rdy_cnt;
    lsu_req = 1'b0;
    sys_rst = 1'b1;
    #1;
    chk("rb_stb_drop", {31'h0, dwb.dwb_stb}, 32'h0);
    chk("rb_stall", {31'h0, lsu_stall}, 32'h0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rb_no_rdy", rdy_cnt - r0, 32'd0);
    chk("rb_idle_stb", {31'h0, dwb.dwb_stb}, 32'h0);

    // 20 mixed back-to-back transactions against the RAM.
    ovr_en = 1'b0;
    r0 = rdy_cnt;
    for (int t = 0; t < 20; t++) begin
      w = 1'(($urandom_range(0, 1)));
      s = 2'($urandom_range(0, 2));
      g = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      off = (s == 2'b00) ? 2'($urandom_range(0, 3)) : (s == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      if (t < 4) w = 1'b1;
      a = {26'h0, idx, off};
      d = $urandom;
      ack_delay = $urandom_range(0, 5);
      txn(w, s, g, a, d, res, err, lat, sel, wadr, dto, wr, stable, stall_done, done);
      chk("rnd_done", {31'h0, done}, 32'h1);
      chk("rnd_sel", {28'h0, sel}, {28'h0, exp_sel(s, off)});
      if (w) begin
        chk("rnd_dto", dto, exp_dto(s, d));
        chk("rnd_st_res", res, 32'h0);
        ref_store(a, s, d);
      end else begin
        chk("rnd_ld_res", res, exp_load(ref_mem[idx], s, g, off));
      end
    end
    @(posedge sys_clk); #1;
    chk("rnd_rdy_count", rdy_cnt - r0, 32'd20);
    chk("stb_gap_ge2", {31'h0, (min_gap >= 2)}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
